// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the UART transmit FIFO: default sizing and the
// drain FSM state encoding used by uart_tx_fifo.
package uart_tx_fifo_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_ADDR_BITS = 4;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the transmit FIFO: one synchronous write port and one
// asynchronous read port, so the popped word is available in the pop cycle.
module fifo_ram
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] w_addr,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic [ADDR_BITS-1:0] r_addr,
  output logic [DATA_BITS-1:0] r_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem [0:DEPTH-1];

  // Store the incoming word at the write pointer when a push is accepted.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer between the CPU write port and the UART transmitter.
// CPU writes land in a 2**ADDR_BITS entry circular FIFO on each rising edge
// of wr; a drain FSM hands words to the transmitter via tx_start/tx_done.
// Define UART_TX_FIFO_OVERFLOW_EN to add a sticky overflow flag (with
// ovf_clr) that records pushes dropped because the FIFO was full.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 wr,
  input  logic                 tx_done,
  output logic [DATA_BITS-1:0] d_in,
  output logic                 tx_start,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic [ADDR_BITS:0]   count
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  input  logic                 ovf_clr,
  output logic                 overflow
`endif
);

  localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 wr_prev;
  logic                 push_edge;
  logic                 push;
  logic                 pop;
  logic [ADDR_BITS:0]   count_next;
  logic [DATA_BITS-1:0] rd_word;
  logic [1:0]           state;
  logic [1:0]           state_next;
  logic                 start_next;

  fifo_ram #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk    (clk),
    .we     (push),
    .w_addr (wr_ptr),
    .w_data (w_data),
    .r_addr (rd_ptr),
    .r_data (rd_word)
  );

  // Track wr even while reset is held, so a strobe already high at release is not seen as a new edge.
  always_ff @(posedge clk) begin
    wr_prev <= wr;
  end

  assign push_edge = wr & ~wr_prev;
  assign push      = push_edge & (~tx_full | pop);

  // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally at the address width; flags are registered from the next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_next;
      tx_full  <= (count_next == DEPTH_CNT);
      tx_empty <= (count_next == '0);
    end
  end

  // The word for the transmitter is captured only at a pop and held for the whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_in <= '0;
    end else if (pop) begin
      d_in <= rd_word;
    end
  end

  // Drain FSM state register; tx_start is registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
    end else begin
      state    <= state_next;
      tx_start <= start_next;
    end
  end

  // Next-state logic: fetch when data is waiting, announce it once, then wait for the frame to end.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!tx_empty) state_next = START;
      START:     state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode: pop leaving IDLE, and raise tx_start for the single cycle spent in START.
  always_comb begin
    pop        = (state == IDLE) && !tx_empty;
    start_next = (state_next == START);
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic dropped;
  assign dropped = push_edge & tx_full & ~pop;

  // Sticky record of dropped pushes; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (dropped) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (DATA_BITS=8, ADDR_BITS=2).
// A queue-based model predicts every output each cycle; directed sequences
// add literal expectations for reset, fill/overflow, drain order, wrap,
// push-while-popping at full, and reset during a frame.
module tb_uart_tx_fifo;

  localparam int DATA_BITS = 8;
  localparam int ADDR_BITS = 2;
  localparam int DEPTH     = 4;

  logic                 clk      = 1'b0;
  logic                 reset    = 1'b1;
  logic [DATA_BITS-1:0] w_data   = '0;
  logic                 wr       = 1'b0;
  logic                 tx_done  = 1'b0;
  logic [DATA_BITS-1:0] d_in;
  logic                 tx_start;
  logic                 tx_full;
  logic                 tx_empty;
  logic [ADDR_BITS:0]   count;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic                 ovf_clr  = 1'b0;
  logic                 overflow;
`endif

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .w_data   (w_data),
    .wr       (wr),
    .tx_done  (tx_done),
    .d_in     (d_in),
    .tx_start (tx_start),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .count    (count)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .ovf_clr  (ovf_clr),
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Compare one value and log a failure line when it differs
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the CPU and transmitter inputs
  task automatic applyStimulus(input logic wr_v, input logic [DATA_BITS-1:0] data_v, input logic done_v);
    wr      = wr_v;
    w_data  = data_v;
    tx_done = done_v;
  endtask

  // One CPU write: wr rises for one cycle then drops for one cycle
  task automatic writeWord(input logic [DATA_BITS-1:0] data_v);
    applyStimulus(1'b1, data_v, 1'b0);
    cycle();
    applyStimulus(1'b0, data_v, 1'b0);
    cycle();
  endtask

  // Signal end of frame one cycle after the current point
  task automatic pulseDone();
    cycle();
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
  endtask

  // Wait (bounded) for tx_start and check the word handed over
  task automatic waitStart(input logic [DATA_BITS-1:0] exp_word);
    for (int i = 0; i < 12; i++) begin
      if (tx_start === 1'b1) break;
      cycle();
    end
    checkOutput("start_seen", {31'd0, tx_start}, 32'd1);
    checkOutput("start_word", {24'd0, d_in}, {24'd0, exp_word});
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_BITS-1:0] q[$];
  logic                 busy        = 1'b0;
  logic                 m_start     = 1'b0;
  logic [DATA_BITS-1:0] m_d         = '0;
  logic                 m_prev      = 1'b0;
  logic                 model_valid = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic                 m_ovf       = 1'b0;
`endif

  always @(posedge clk) begin
    logic rise, do_pop, done_seen, dropped;
    if (reset) begin
      q.delete();
      busy        = 1'b0;
      m_start     = 1'b0;
      m_d         = '0;
      m_prev      = wr;
      model_valid = 1'b1;
`ifdef UART_TX_FIFO_OVERFLOW_EN
      m_ovf       = 1'b0;
`endif
    end else begin
      rise      = wr && !m_prev;
      do_pop    = !busy && (q.size() > 0);
      done_seen = busy && !m_start && tx_done;
      dropped   = 1'b0;
      if (do_pop) m_d = q.pop_front();
      if (rise) begin
        if (q.size() < DEPTH) q.push_back(w_data);
        else dropped = 1'b1;
      end
`ifdef UART_TX_FIFO_OVERFLOW_EN
      if (dropped) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
`endif
      busy    = do_pop || (busy && !done_seen);
      m_start = do_pop;
      m_prev  = wr;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("cmp_d_in", {24'd0, d_in}, {24'd0, m_d});
      checkOutput("cmp_tx_start", {31'd0, tx_start}, {31'd0, m_start});
      checkOutput("cmp_count", {29'd0, count}, q.size());
      checkOutput("cmp_tx_full", {31'd0, tx_full}, {31'd0, (q.size() == DEPTH)});
      checkOutput("cmp_tx_empty", {31'd0, tx_empty}, {31'd0, (q.size() == 0)});
`ifdef UART_TX_FIFO_OVERFLOW_EN
      checkOutput("cmp_overflow", {31'd0, overflow}, {31'd0, m_ovf});
`endif
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Test 1: reset then a single held write
    cycle();
    cycle();
    reset = 1'b0;
    checkOutput("rst_count", {29'd0, count}, 32'd0);
    checkOutput("rst_empty", {31'd0, tx_empty}, 32'd1);
    checkOutput("rst_full", {31'd0, tx_full}, 32'd0);
    checkOutput("rst_start", {31'd0, tx_start}, 32'd0);
    checkOutput("rst_d_in", {24'd0, d_in}, 32'd0);
    applyStimulus(1'b1, 8'h32, 1'b0);
    cycle();
    checkOutput("t1_count_push", {29'd0, count}, 32'd1);
    checkOutput("t1_no_start_yet", {31'd0, tx_start}, 32'd0);
    cycle();
    checkOutput("t1_start", {31'd0, tx_start}, 32'd1);
    checkOutput("t1_d_in", {24'd0, d_in}, 32'h32);
    checkOutput("t1_count_pop", {29'd0, count}, 32'd0);
    cycle();
    applyStimulus(1'b0, 8'h32, 1'b0);
    checkOutput("t1_start_single", {31'd0, tx_start}, 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    checkOutput("t1_held_count", {29'd0, count}, 32'd0);
    checkOutput("t1_held_d_in", {24'd0, d_in}, 32'h32);
    pulseDone();
    cycle();
    checkOutput("t1_idle_no_start", {31'd0, tx_start}, 32'd0);

    // Test 2: fill to DEPTH and beyond
    for (int i = 1; i <= 4; i++) writeWord(8'(i));
    checkOutput("t2_count3", {29'd0, count}, 32'd3);
    checkOutput("t2_not_full", {31'd0, tx_full}, 32'd0);
    writeWord(8'h05);
    checkOutput("t2_count4", {29'd0, count}, 32'd4);
    checkOutput("t2_full", {31'd0, tx_full}, 32'd1);
    writeWord(8'h06);
    checkOutput("t2_drop_count", {29'd0, count}, 32'd4);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    checkOutput("t2_overflow", {31'd0, overflow}, 32'd1);
`endif
    writeWord(8'h07);
    checkOutput("t2_drop_count2", {29'd0, count}, 32'd4);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    checkOutput("t2_ovf_clear", {31'd0, overflow}, 32'd0);
`endif

    // Test 3: drain; 0x06 and 0x07 were dropped while full
    for (int i = 2; i <= 5; i++) begin
      pulseDone();
      waitStart(8'(i));
    end
    pulseDone();
    for (int i = 0; i < 3; i++) cycle();
    checkOutput("t3_empty", {31'd0, tx_empty}, 32'd1);
    checkOutput("t3_count", {29'd0, count}, 32'd0);
    checkOutput("t3_idle", {31'd0, tx_start}, 32'd0);

    // Test 4: pointer wrap over ten write/drain pairs
    for (int i = 0; i < 10; i++) begin
      writeWord(8'hA0 + 8'(i));
      waitStart(8'hA0 + 8'(i));
      pulseDone();
    end

    // Test 5: push arriving in the pop cycle while full
    for (int i = 0; i < 5; i++) writeWord(8'hB0 + 8'(i));
    checkOutput("t5_full_before", {31'd0, tx_full}, 32'd1);
    cycle();
    tx_done = 1'b1;
    cycle();
    applyStimulus(1'b1, 8'h55, 1'b0);
    cycle();
    checkOutput("t5_count", {29'd0, count}, 32'd4);
    checkOutput("t5_full", {31'd0, tx_full}, 32'd1);
    checkOutput("t5_start", {31'd0, tx_start}, 32'd1);
    checkOutput("t5_word", {24'd0, d_in}, 32'hB1);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    checkOutput("t5_no_ovf", {31'd0, overflow}, 32'd0);
`endif
    applyStimulus(1'b0, 8'h55, 1'b0);
    cycle();
    for (int i = 2; i <= 4; i++) begin
      pulseDone();
      waitStart(8'hB0 + 8'(i));
    end
    pulseDone();
    waitStart(8'h55);
    pulseDone();

    // Test 6: reset during WAIT_DONE with three words queued
    for (int i = 0; i < 4; i++) writeWord(8'hC0 + 8'(i));
    checkOutput("t6_count3", {29'd0, count}, 32'd3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("t6_count0", {29'd0, count}, 32'd0);
    checkOutput("t6_empty", {31'd0, tx_empty}, 32'd1);
    checkOutput("t6_start", {31'd0, tx_start}, 32'd0);
    checkOutput("t6_d_in", {24'd0, d_in}, 32'd0);
    cycle();
    pulseDone();
    cycle();
    checkOutput("t6_late_done_a", {31'd0, tx_start}, 32'd0);
    cycle();
    checkOutput("t6_late_done_b", {31'd0, tx_start}, 32'd0);

    // wr held high across reset release writes nothing until it rises again
    reset = 1'b1;
    applyStimulus(1'b1, 8'hEE, 1'b0);
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    checkOutput("wr_held_count", {29'd0, count}, 32'd0);
    checkOutput("wr_held_start", {31'd0, tx_start}, 32'd0);
    applyStimulus(1'b0, 8'hEE, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'hD7, 1'b0);
    cycle();
    checkOutput("wr_rerise_count", {29'd0, count}, 32'd1);
    applyStimulus(1'b0, 8'hD7, 1'b0);
    cycle();
    waitStart(8'hD7);
    pulseDone();
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
